// File: rtl/lod_denorm_pipe_if.sv
// Handshake and data bundle for the denormalising shifter.
// The slave side is the shifter itself; the master side is whoever feeds
// it counts and fractions and consumes the rebuilt words.
interface lod_denorm_pipe_if #(
   parameter int N = 16
) ();
   localparam int S = $clog2(N);

   logic         in_valid;
   logic         in_ready;
   logic [S-1:0] in_lzc;
   logic [N-2:0] in_frac;
   logic         in_zero;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_sticky;
   logic         out_vld;

   modport master (
      output in_valid,
      output in_lzc,
      output in_frac,
      output in_zero,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sticky,
      input  out_vld
   );

   modport slave (
      input  in_valid,
      input  in_lzc,
      input  in_frac,
      input  in_zero,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sticky,
      output out_vld
   );
endinterface

// File: rtl/lod_denorm_pipe.sv
// Inverse leading-one detector: rebuilds an N-bit word from a leading-zero
// count and the fraction bits under the hidden one, as {1, frac} >> lzc.
// Implemented as an S-stage logarithmic right shifter; stage k consumes the
// count bit worth 2^(S-1-k). Bits falling off the bottom fold into sticky.
// All stages share one enable, so a stall freezes the whole pipe.
module lod_denorm_pipe #(
   parameter int N = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   lod_denorm_pipe_if.slave  bus
);
   localparam int S = $clog2(N);

   logic w_en;

   assign w_en        = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = rst_n & w_en;

   for (genvar k = 0; k < S; k++) begin : g_stage
      // Shift distance handled here and width of the count still to consume.
      localparam int SH = 2 ** (S - 1 - k);
      localparam int CW = S - k;

      logic          w_inValid;
      logic          w_inSticky;
      logic          w_inZero;
      logic [N-1:0]  w_inData;
      logic [CW-1:0] w_inCnt;
      logic [N-1:0]  w_shData;
      logic          w_lost;

      logic          r_valid;
      logic          r_sticky;
      logic          r_zero;
      logic [N-1:0]  r_data;

      if (k == 0) begin : g_src
         // A zero value enters as an all-zero word so that it leaves as zero
         // with no sticky, whatever count and fraction came along with it.
         assign w_inValid  = bus.in_valid;
         assign w_inData   = bus.in_zero ? '0 : {1'b1, bus.in_frac};
         assign w_inCnt    = bus.in_lzc;
         assign w_inSticky = 1'b0;
         assign w_inZero   = bus.in_zero;
      end else begin : g_src
         assign w_inValid  = g_stage[k-1].r_valid;
         assign w_inData   = g_stage[k-1].r_data;
         assign w_inCnt    = g_stage[k-1].g_rem.r_rem;
         assign w_inSticky = g_stage[k-1].r_sticky;
         assign w_inZero   = g_stage[k-1].r_zero;
      end

      assign w_shData = w_inCnt[CW-1] ? (w_inData >> SH) : w_inData;
      assign w_lost   = w_inCnt[CW-1] & (|w_inData[SH-1:0]);

      // Stage register: advances with the global enable, bubbles ride along.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
         end else if (w_en) begin
            r_valid  <= w_inValid;
            r_data   <= w_shData;
            r_sticky <= w_inSticky | w_lost;
            r_zero   <= w_inZero;
         end
      end

      if (k < S - 1) begin : g_rem
         logic [CW-2:0] r_rem;

         // Carry only the count bits that later stages still need.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_rem <= '0;
            end else if (w_en) begin
               r_rem <= w_inCnt[CW-2:0];
            end
         end
      end
   end

   assign bus.out_valid  = g_stage[S-1].r_valid;
   assign bus.out_data   = g_stage[S-1].r_data;
   assign bus.out_sticky = g_stage[S-1].r_sticky;
   assign bus.out_vld    = g_stage[S-1].r_valid & ~g_stage[S-1].r_zero;

endmodule

// File: tb/tb_lod_denorm_pipe.sv
// Self-checking bench for lod_denorm_pipe at N=16. Accepted words push their
// expected result to a queue; retired outputs pop and compare.
module tb_lod_denorm_pipe;
   localparam int N = 16;
   localparam int S = 4;

   typedef struct {
      logic [N-1:0] data;
      logic         sticky;
      logic         vld;
      logic [S-1:0] lzc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic randReady;
   int   assertCount;
   int   failCount;
   exp_t sbQueue[$];

   logic         prevStalled;
   logic [N-1:0] prevData;
   logic         prevSticky;
   logic         prevVld;

   lod_denorm_pipe_if #(.N(N)) bus ();

   lod_denorm_pipe #(.N(N)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never completes.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: place the hidden one, shift through a double-width window,
   // the low half collects whatever fell off.
   function automatic exp_t modelDenorm(input logic [S-1:0] lzc, input logic [N-2:0] frac,
                                        input logic zero);
      exp_t             e;
      logic [2*N-1:0]   wide;
      wide     = {1'b1, frac, {N{1'b0}}};
      wide     = wide >> lzc;
      e.lzc    = lzc;
      e.data   = zero ? '0 : wide[2*N-1:N];
      e.sticky = zero ? 1'b0 : (|wide[N-1:0]);
      e.vld    = ~zero;
      return e;
   endfunction

   // Independent leading-one detector used for the round-trip property.
   function automatic logic [S:0] lod16(input logic [N-1:0] w);
      logic [S:0] cnt;
      logic       found;
      cnt   = N[S:0];
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!found && w[i]) begin
            cnt   = (S+1)'(N - 1 - i);
            found = 1'b1;
         end
      end
      return cnt;
   endfunction

   // Offer one word and hold it until accepted; the expected result is queued
   // on acceptance. in_valid stays high so callers can stream back-to-back.
   task automatic applyStimulus(input logic [S-1:0] lzc, input logic [N-2:0] frac,
                                input logic zero, input logic [N-1:0] expData,
                                input logic expSticky, input logic expVld);
      logic acc;
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_lzc   = lzc;
      bus.in_frac  = frac;
      bus.in_zero  = zero;
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (acc) begin
         e.data   = expData;
         e.sticky = expSticky;
         e.vld    = expVld;
         e.lzc    = lzc;
         sbQueue.push_back(e);
      end else begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
      end
   endtask

   task automatic sendModel(input logic [S-1:0] lzc, input logic [N-2:0] frac,
                            input logic zero);
      exp_t e;
      e = modelDenorm(lzc, frac, zero);
      applyStimulus(lzc, frac, zero, e.data, e.sticky, e.vld);
   endtask

   // Stop offering, release backpressure and wait for the queue to empty.
   task automatic drain();
      int c;
      bus.in_valid  = 1'b0;
      randReady     = 1'b0;
      bus.out_ready = 1'b1;
      c = 0;
      while (sbQueue.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      checkOutput("drainLeft", sbQueue.size(), 32'd0);
   endtask

   // Pseudo-random backpressure while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor on the falling edge: handshake rule, stall stability, scoreboard.
   initial begin
      prevStalled = 1'b0;
      forever begin
         @(negedge clk);
         checkOutput("inReady", {31'd0, bus.in_ready},
                     {31'd0, rst_n & (~bus.out_valid | bus.out_ready)});
         if (rst_n && prevStalled) begin
            checkOutput("stallData", bus.out_data, prevData);
            checkOutput("stallSticky", bus.out_sticky, prevSticky);
            checkOutput("stallVld", bus.out_vld, prevVld);
            checkOutput("stallValid", bus.out_valid, 32'd1);
         end
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpectedOut", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbQueue.pop_front();
               checkOutput("outData", bus.out_data, e.data);
               checkOutput("outSticky", bus.out_sticky, e.sticky);
               checkOutput("outVld", bus.out_vld, e.vld);
               if (e.vld) checkOutput("roundTrip", lod16(bus.out_data), {28'd0, e.lzc});
            end
         end
         prevStalled = rst_n & bus.out_valid & ~bus.out_ready;
         prevData    = bus.out_data;
         prevSticky  = bus.out_sticky;
         prevVld     = bus.out_vld;
      end
   end

   initial begin
      assertCount   = 0;
      failCount     = 0;
      randReady     = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_lzc    = '0;
      bus.in_frac   = '0;
      bus.in_zero   = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstValid", bus.out_valid, 32'd0);
      checkOutput("rstData", bus.out_data, 32'd0);
      checkOutput("rstSticky", bus.out_sticky, 32'd0);
      checkOutput("rstVld", bus.out_vld, 32'd0);
      checkOutput("rstInReady", bus.in_ready, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] directed words");
      applyStimulus(4'd0, 15'h7FFF, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      drain();
      applyStimulus(4'd3, 15'h0007, 1'b0, 16'h1000, 1'b1, 1'b1);
      drain();
      applyStimulus(4'd15, 15'h0000, 1'b0, 16'h0001, 1'b0, 1'b1);
      drain();
      applyStimulus(4'd15, 15'h4000, 1'b0, 16'h0001, 1'b1, 1'b1);
      drain();
      applyStimulus(4'd5, 15'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);
      drain();

      $display("[TB] streaming with random backpressure");
      randReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sendModel(4'($urandom_range(0, 15)), 15'($urandom), 1'(i == 6));
      end
      drain();

      $display("[TB] reset with words in flight");
      bus.out_ready = 1'b1;
      applyStimulus(4'd1, 15'h0ABC, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(4'd2, 15'h1111, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(4'd4, 15'h2222, 1'b0, 16'h0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      sbQueue.delete();
      rst_n = 1'b1;
      for (int c = 0; c < S; c++) begin
         @(negedge clk);
         checkOutput("postRstValid", bus.out_valid, 32'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] round trip over every count");
      for (int l = 0; l < N; l++) begin
         sendModel(4'(l), 15'($urandom), 1'b0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
